// File: rtl/crg_rst_seq.sv
// Reset release sequencer: holds each channel reset for HOLD cycles after a request, then releases in parallel or staged order.
// Latency: rst_no[k] rises HOLD+1 edges after the last request/reset edge (parallel); staged releases are GAP cycles apart.
// Backpressure: none; rst_req_i overrides every transition. CRG_RST_SEQ_STUCK_EN adds sticky stuck-request flags.
module crg_rst_seq #(
  parameter int N           = 8,
  parameter int HOLD        = 1295,
  parameter int GAP         = 16,
  parameter int STUCK_LIMIT = 4096
) (
  input  logic         ref_clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] rst_req_i,
  input  logic         seq_en_i,
  output logic [N-1:0] rst_no,
  output logic         busy_o,
  output logic [N-1:0] stuck_o
);

  localparam int CW = $clog2(HOLD);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP - 1);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RUN    = 2'd2
  } chan_state_e;

  // Refuse to elaborate with parameters that would break the counter sizing.
  if (N < 1 || HOLD < 2 || GAP < 1 || STUCK_LIMIT < 1) begin : g_param_check
    $error("crg_rst_seq: illegal parameter combination");
  end

  chan_state_e   st_q  [N];
  chan_state_e   st_d  [N];
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_d;
  logic [N-1:0]  grant;
  logic [N-1:0]  run_d;
  logic          staged_grant;

  // Grant selection: all WAIT channels in parallel mode; in staged mode only the
  // lowest WAIT channel whose lower neighbours are all RUN, and only once the gap
  // counter has drained. A channel requesting this cycle is never granted.
  always_comb begin
    logic lower_clear;
    grant       = '0;
    lower_clear = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (st_q[k] == ST_WAIT && !rst_req_i[k]) begin
        if (!seq_en_i) begin
          grant[k] = 1'b1;
        end else if (lower_clear && gap_q == '0) begin
          grant[k] = 1'b1;
        end
      end
      if (st_q[k] != ST_RUN) begin
        lower_clear = 1'b0;
      end
    end
    staged_grant = seq_en_i && (|grant);
  end

  // Gap counter: reload on a staged grant, otherwise count down and park at 0.
  always_comb begin
    gap_d = gap_q;
    if (staged_grant) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  // Per-channel next state; a request wins over every other transition.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      st_d[k]  = st_q[k];
      cnt_d[k] = cnt_q[k];
      if (rst_req_i[k]) begin
        st_d[k]  = ST_ASSERT;
        cnt_d[k] = '0;
      end else begin
        case (st_q[k])
          ST_ASSERT: begin
            if (cnt_q[k] == HOLD_LAST) begin
              st_d[k] = ST_WAIT;
            end else begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end
          ST_WAIT: begin
            if (grant[k]) begin
              st_d[k] = ST_RUN;
            end
          end
          ST_RUN:  st_d[k] = ST_RUN;
          default: st_d[k] = ST_ASSERT;
        endcase
      end
      run_d[k] = (st_d[k] == ST_RUN);
    end
  end

  // State, counters and registered outputs; outputs reflect the next state.
  always_ff @(posedge ref_clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < N; k++) begin
        st_q[k]  <= ST_ASSERT;
        cnt_q[k] <= '0;
      end
      gap_q  <= '0;
      rst_no <= '0;
      busy_o <= 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        st_q[k]  <= st_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      gap_q  <= gap_d;
      rst_no <= run_d;
      busy_o <= ~(&run_d);
    end
  end

`ifdef CRG_RST_SEQ_STUCK_EN
  localparam int SW = $clog2(STUCK_LIMIT + 1);
  localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_LIMIT);
  localparam logic [SW-1:0] STUCK_PREV = SW'(STUCK_LIMIT - 1);

  logic [SW-1:0] stk_cnt_q [N];
  logic [N-1:0]  stuck_q;

  // Count consecutive request cycles (saturating); flag latches until rst_ni.
  always_ff @(posedge ref_clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < N; k++) begin
        stk_cnt_q[k] <= '0;
      end
      stuck_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (rst_req_i[k]) begin
          if (stk_cnt_q[k] != STUCK_MAX) begin
            stk_cnt_q[k] <= stk_cnt_q[k] + 1'b1;
          end
          if (stk_cnt_q[k] >= STUCK_PREV) begin
            stuck_q[k] <= 1'b1;
          end
        end else begin
          stk_cnt_q[k] <= '0;
        end
      end
    end
  end

  assign stuck_o = stuck_q;
`else
  assign stuck_o = '0;
`endif

endmodule

// File: tb/tb_crg_rst_seq.sv
// Directed bench for crg_rst_seq with N=4, HOLD=4, GAP=2, STUCK_LIMIT=8.
// Edges are numbered from the last edge that sampled rst_ni=0 (edge 0).
module tb_crg_rst_seq;
  localparam int N  = 4;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int SL   = 8;

`ifdef CRG_RST_SEQ_STUCK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic         ref_clk_i = 1'b0;
  logic         rst_ni;
  logic [N-1:0] rst_req_i;
  logic         seq_en_i;
  logic [N-1:0] rst_no;
  logic         busy_o;
  logic [N-1:0] stuck_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_v;

  always #5 ref_clk_i = ~ref_clk_i;

  crg_rst_seq #(.N(N), .HOLD(HOLD), .GAP(GAP), .STUCK_LIMIT(SL)) dut (
    .ref_clk_i (ref_clk_i),
    .rst_ni    (rst_ni),
    .rst_req_i (rst_req_i),
    .seq_en_i  (seq_en_i),
    .rst_no    (rst_no),
    .busy_o    (busy_o),
    .stuck_o   (stuck_o)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ref_clk_i);
    #1;
  endtask

  task automatic do_reset(input logic seq);
    rst_ni    = 1'b0;
    rst_req_i = '0;
    seq_en_i  = seq;
    repeat (3) step();
    chk("reset rst_no", {4'h0, rst_no}, 8'h00);
    chk("reset busy", {7'h0, busy_o}, 8'h01);
    chk("reset stuck", {4'h0, stuck_o}, 8'h00);
    rst_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni    = 1'b0;
    rst_req_i = '0;
    seq_en_i  = 1'b0;

    // Test 1: parallel release at edge HOLD+1 = 5.
    do_reset(1'b0);
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("t1 rst_no e%0d", e), {4'h0, rst_no}, (e >= 5) ? 8'h0F : 8'h00);
      chk($sformatf("t1 busy e%0d", e), {7'h0, busy_o}, (e < 5) ? 8'h01 : 8'h00);
    end

    // Test 2: staged release at edges 5, 7, 9, 11.
    do_reset(1'b1);
    for (int e = 1; e <= 12; e++) begin
      step();
      exp_v = {4'h0, e >= 11, e >= 9, e >= 7, e >= 5};
      chk($sformatf("t2 rst_no e%0d", e), {4'h0, rst_no}, exp_v);
      chk($sformatf("t2 busy e%0d", e), {7'h0, busy_o}, (e < 11) ? 8'h01 : 8'h00);
    end

    // Test 3: one-cycle request on channel 2 while everything runs.
    seq_en_i = 1'b0;
    step();
    chk("t3 pre rst_no", {4'h0, rst_no}, 8'h0F);
    rst_req_i = 4'b0100;
    step();
    chk("t3 pulse rst_no", {4'h0, rst_no}, 8'h0B);
    chk("t3 pulse busy", {7'h0, busy_o}, 8'h01);
    rst_req_i = '0;
    for (int d = 1; d <= 5; d++) begin
      step();
      chk($sformatf("t3 rst_no d%0d", d), {4'h0, rst_no}, (d >= 5) ? 8'h0F : 8'h0B);
      chk($sformatf("t3 busy d%0d", d), {7'h0, busy_o}, (d < 5) ? 8'h01 : 8'h00);
    end

    // Test 4: channel 1 held in request for edges 1..20 blocks channels 2 and 3.
    do_reset(1'b1);
    rst_req_i = 4'b0010;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (e == 20) rst_req_i = '0;
      exp_v = {4'h0, e >= 29, e >= 27, e >= 25, e >= 5};
      chk($sformatf("t4 rst_no e%0d", e), {4'h0, rst_no}, exp_v);
      chk($sformatf("t4 busy e%0d", e), {7'h0, busy_o}, (e < 29) ? 8'h01 : 8'h00);
    end
    chk("t4 stuck", {4'h0, stuck_o}, STK ? 8'h02 : 8'h00);

    // Test 5: switching to parallel after channel 0 releases frees the rest at once.
    do_reset(1'b1);
    repeat (4) step();
    chk("t5 rst_no e4", {4'h0, rst_no}, 8'h00);
    step();
    chk("t5 rst_no e5", {4'h0, rst_no}, 8'h01);
    seq_en_i = 1'b0;
    step();
    chk("t5 rst_no e6", {4'h0, rst_no}, 8'h0F);
    chk("t5 busy e6", {7'h0, busy_o}, 8'h00);

    // Test 6: channel 3 requests for 8 consecutive cycles.
    rst_req_i = 4'b1000;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("t6 stuck c%0d", i), {4'h0, stuck_o}, (STK && i == 8) ? 8'h08 : 8'h00);
    end
    chk("t6 rst_no held", {4'h0, rst_no}, 8'h07);
    rst_req_i = '0;
    repeat (3) step();
    chk("t6 stuck sticky", {4'h0, stuck_o}, STK ? 8'h08 : 8'h00);
    rst_ni = 1'b0;
    step();
    chk("t6 stuck cleared", {4'h0, stuck_o}, 8'h00);
    chk("t6 rst_no in reset", {4'h0, rst_no}, 8'h00);
    chk("t6 busy in reset", {7'h0, busy_o}, 8'h01);
    rst_ni = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/crg_rst_seq.md
Name: crg_rst_seq

Overview:
- Parametrised reset release sequencer for the CRG. Successor to the fixed-delay per-output reset path.
- Holds each of N channel resets asserted for at least HOLD ref-clock cycles after any request.
- Releases channels either all together (parallel mode) or in ascending index order, GAP cycles apart (staged mode).
- Sits between the global/request reset logic and the per-domain reset synchronisers.

Parameters:
- N, 8, number of reset channels (>=1)
- HOLD, 1295, minimum assertion length in cycles (>=2)
- GAP, 16, cycles between consecutive staged releases (>=1)
- STUCK_LIMIT, 4096, consecutive request cycles before the stuck flag sets (optional feature only)

Ports:
- ref_clk_i  input  1  sequencer clock
- rst_ni  input  1  reset, synchronous, active-low
- rst_req_i  input  N  per-channel reset request, active-high, synchronous to ref_clk_i
- seq_en_i  input  1  1 = staged release, 0 = parallel release; sampled every cycle
- rst_no  output  N  per-channel reset, active-low, registered
- busy_o  output  1  1 while any channel is not in RUN
- stuck_o  output  N  sticky stuck-request flags (tied 0 when the feature is off)

Behaviour:
- Interface (already decided): one clock, ref_clk_i; reset rst_ni is synchronous and active-low.
- While rst_ni=0 at a clock edge:
  - all channels go to ASSERT with counter 0;
  - gap counter = 0;
  - rst_no = all 0, busy_o = 1, stuck_o = all 0.
- Per-channel FSM:
  - ASSERT: rst_no[k]=0.
    - rst_req_i[k]=1 clears the counter.
    - Otherwise the counter increments.
    - When the counter = HOLD-1 and the request is low, go to WAIT.
  - WAIT: rst_no[k]=0.
    - Go to RUN when granted.
    - rst_req_i[k]=1 returns to ASSERT with counter 0.
  - RUN: rst_no[k]=1.
    - rst_req_i[k]=1 returns to ASSERT with counter 0. rst_no[k] falls on the next edge (1-cycle latency).
- A request has priority over every other transition in every state.
- Grant in parallel mode: every channel in WAIT is granted in the same cycle. No gap counter is used.
- Grant in staged mode: channel k in WAIT is granted only when:
  - no channel j<k is in ASSERT or WAIT;
  - the gap counter = 0;
  - at most one grant occurs per cycle.
- Gap counter: loads GAP-1 on each staged grant, decrements to 0 and saturates there.
- Re-assertion of a channel never cascades: channels already in RUN are untouched. Higher-index channels still in WAIT block until it re-releases.
- seq_en_i changing mid-sequence:
  - takes effect the next cycle;
  - a switch to parallel mode releases all WAIT channels at once;
  - the gap counter keeps counting.
- Counter width: $clog2(HOLD). Gap counter width: $clog2(GAP+1). No wrap-around possible.
- busy_o is registered, derived from next state: 0 only when all channels are in RUN.
- Release timing (parallel mode): rst_no[k] rises on the (HOLD+1)th edge after the last edge at which rst_req_i[k]=1 or rst_ni=0 was sampled.

Optional Feature:
- Macro: CRG_RST_SEQ_STUCK_EN.
- With the macro defined:
  - a per-channel counter counts consecutive cycles with rst_req_i[k]=1 and saturates;
  - stuck_o[k] sets when that count reaches STUCK_LIMIT;
  - stuck_o[k] is sticky until rst_ni=0 (request deassertion does not clear it);
  - reset behaviour is unaffected.
- Without the macro: the counters are not generated and stuck_o = all 0 constantly.

Test Plan:
- All scenarios use N=4, HOLD=4, GAP=2, STUCK_LIMIT=8.
1. Reset, parallel: rst_ni low 3 cycles, then high, seq_en_i=0, no requests -> rst_no=0000 until edge 5 after release, then 1111; busy_o falls on the same edge.
2. Staged release: as test 1 with seq_en_i=1 -> rst_no[0] rises at edge 5, [1] at 7, [2] at 9, [3] at 11; busy_o=0 from edge 11.
3. Re-request in RUN: all channels in RUN, pulse rst_req_i[2] for 1 cycle -> rst_no[2]=0 next edge, back to 1 five edges after the pulse; other bits stay 1; busy_o=1 during that window.
4. Ordering block: staged mode, hold rst_req_i[1]=1 for 20 cycles after reset -> channel 0 releases at edge 5; channels 2 and 3 stay 0 until channel 1 releases, then follow at +2 and +4 cycles.
5. Mode switch: staged mode, after channel 0 releases, drive seq_en_i=0 -> channels 1–3 release together one edge later.
6. Stuck flag (macro on): hold rst_req_i[3]=1 for 8 cycles -> stuck_o[3]=1, stays 1 after the request drops, clears only on rst_ni=0. Macro off: stuck_o stays 0000.
